sram_req_ctrl: RTL and testbench
================================

Name: sram_req_ctrl

Overview:
- Request-side controller sitting directly upstream of the single-port RAM (SinglePortRam); sole master of its cs/wr_e/oe/address/bidirectional data pins.
- Accepts single read/write requests over a valid/ready handshake, sequences RAM bus cycles, owns bus turnaround, returns read data with a one-cycle valid pulse.

Parameters:
ADDR_W, 7, RAM address width (128 words)
DATA_W, 8, RAM data width

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  reset, asynchronous, active-high
i_req_valid  in  1  request present
o_req_ready  out  1  controller can accept request this cycle
i_req_wr  in  1  1 = write, 0 = read
i_req_addr  in  ADDR_W  request address
i_req_wdata  in  DATA_W  write data
o_rd_valid  out  1  one-cycle pulse, o_rd_data valid
o_rd_data  out  DATA_W  captured read data, held until next read completes
o_busy  out  1  state != IDLE
o_cs  out  1  RAM chip select
o_wr_e  out  1  RAM write enable
o_oe  out  1  RAM output enable
o_address  out  ADDR_W  RAM address
io_data  inout  DATA_W  RAM data bus

Behaviour:
- Reset (async, active-high): state=IDLE; o_cs=0, o_wr_e=0, o_oe=0, o_address=0, o_rd_data=0, o_rd_valid=0, o_busy=0, o_req_ready=1; io_data=Z.
- o_req_ready = (state==IDLE) && !i_rst; acceptance = i_req_valid && o_req_ready; request fields registered on acceptance.
- FSM states: IDLE, WRITE, RD_ADDR, RD_WAIT, TURN.
- IDLE: cs=0, wr_e=0, oe=0, io_data=Z. On acceptance -> WRITE (i_req_wr=1) or RD_ADDR (i_req_wr=0).
- WRITE (1 cycle): cs=1, wr_e=1, oe=0, address=reg addr, io_data driven with reg wdata. RAM samples at end of this cycle. -> IDLE.
- RD_ADDR: cs=1, wr_e=0, oe=1, address=reg addr, io_data=Z. -> RD_WAIT.
- RD_WAIT: same pin values; io_data sampled into o_rd_data at end of cycle. -> TURN.
- TURN: cs=0, oe=0, io_data=Z; o_rd_valid=1 this cycle only. -> IDLE.
- Latency from acceptance cycle N: write on RAM pins N+1, ready again N+2; read pins N+1..N+2, o_rd_valid N+3, ready again N+4.
- io_data driven only in WRITE; never driven while o_oe=1 (contention-free invariant). TURN guarantees ≥1 idle cycle between RAM driving and controller driving.
- All RAM pin outputs registered (no combinational path from i_req_* to RAM pins).
- i_req_valid while not ready: ignored, no side effects; requester must hold.
- Address wrap: none internal; any ADDR_W value legal, 0 and 2^ADDR_W-1 included.
- Reset mid-operation: bus immediately released (cs/wr_e/oe=0, io_data=Z); in-flight write may be lost; in-flight read produces no o_rd_valid.
- o_rd_data unchanged by writes.

Optional Feature:
- Macro SRAM_REQ_CTRL_STATS_EN.
- Defined: adds outputs o_wr_count[15:0], o_rd_count[15:0]; increment on entering WRITE / on o_rd_valid; saturate at 16'hFFFF; cleared by i_rst.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package sram_ctrl_pkg: state enum (IDLE, WRITE, RD_ADDR, RD_WAIT, TURN), default ADDR_W/DATA_W constants, stats counter width constant.
- One natural sub-module: sram_bus_drv — tri-state driver for io_data (enable, out data, in data); keeps inout handling out of the FSM.

Test Plan:
- Reset asserted mid-RD_WAIT -> next cycle pins cs=0/oe=0, io_data=Z, no o_rd_valid, o_req_ready=1 after release.
- Write addr 0..127 with data = addr^8'h5A back-to-back (valid held) -> each accepted every 2 cycles, WRITE cycle shows cs=1, wr_e=1, oe=0, correct address/data.
- Read addr 0..127 -> o_rd_valid 3 cycles after each acceptance, o_rd_data = addr^8'h5A, ready every 4 cycles.
- Write 8'hA5 to 7'h7F then immediate read of 7'h7F -> o_rd_data=8'hA5; io_data Z in RD_ADDR/RD_WAIT/TURN.
- Bus-contention monitor over random mix of 500 requests -> never io_data driven by controller while o_oe=1; scoreboard matches all reads.
- With SRAM_REQ_CTRL_STATS_EN: 3 writes + 2 reads -> o_wr_count=3, o_rd_count=2; forced 16'hFFFF then one write -> stays 16'hFFFF.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the SRAM request controller
package sram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W = 7;
  localparam int unsigned SRAM_DATA_W = 8;
  localparam int unsigned STATS_W     = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_WAIT = 3'd3,
    TURN    = 3'd4
  } sram_state_e;

  // Saturating increment: a stuck-at-max counter is more useful than a wrapped one
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (&v) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/sram_bus_drv.sv
// rtl/sram_bus_drv.sv - tri-state driver for the bidirectional RAM data bus
module sram_bus_drv #(
  parameter int W = 8
) (
  input  logic         en,
  input  logic [W-1:0] dout,
  output logic [W-1:0] din,
  inout  wire  [W-1:0] bus
);

  assign bus = en ? dout : {W{1'bz}};
  assign din = bus;

endmodule

// File: rtl/sram_req_ctrl.sv
// rtl/sram_req_ctrl.sv - single-request SRAM bus sequencer; SRAM_REQ_CTRL_STATS_EN adds request counters
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic              o_cs,
  output logic              o_wr_e,
  output logic              o_oe,
  output logic [ADDR_W-1:0] o_address,
`ifdef SRAM_REQ_CTRL_STATS_EN
  output logic [STATS_W-1:0] o_wr_count,
  output logic [STATS_W-1:0] o_rd_count,
`endif
  inout  wire  [DATA_W-1:0] io_data
);

  sram_state_e       state;
  logic              drv_en;
  logic [DATA_W-1:0] drv_data;
  logic [DATA_W-1:0] bus_din;
  logic              accept;

  assign o_req_ready = (state == IDLE) && !i_rst;
  assign o_busy      = (state != IDLE);
  assign accept      = i_req_valid && o_req_ready;

  sram_bus_drv #(.W(DATA_W)) u_drv (
    .en   (drv_en),
    .dout (drv_data),
    .din  (bus_din),
    .bus  (io_data)
  );

  // Sequencer: every RAM pin is registered so request inputs never reach the bus combinationally
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      o_cs       <= 1'b0;
      o_wr_e     <= 1'b0;
      o_oe       <= 1'b0;
      o_address  <= '0;
      drv_en     <= 1'b0;
      drv_data   <= '0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            o_address <= i_req_addr;
            o_cs      <= 1'b1;
            if (i_req_wr) begin
              state    <= WRITE;
              o_wr_e   <= 1'b1;
              drv_en   <= 1'b1;
              drv_data <= i_req_wdata;
            end else begin
              state <= RD_ADDR;
              o_oe  <= 1'b1;
            end
          end
        end
        WRITE: begin
          state  <= IDLE;
          o_cs   <= 1'b0;
          o_wr_e <= 1'b0;
          drv_en <= 1'b0;
        end
        RD_ADDR: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          // RAM has had a full cycle of oe; capture and release the bus
          state      <= TURN;
          o_cs       <= 1'b0;
          o_oe       <= 1'b0;
          o_rd_data  <= bus_din;
          o_rd_valid <= 1'b1;
        end
        TURN: begin
          // Dead cycle so the RAM output driver is off before we may drive again
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          o_cs   <= 1'b0;
          o_wr_e <= 1'b0;
          o_oe   <= 1'b0;
          drv_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef SRAM_REQ_CTRL_STATS_EN
  // Request counters: writes counted on entry to WRITE, reads as o_rd_valid is raised
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wr_count <= '0;
      o_rd_count <= '0;
    end else begin
      if (accept && i_req_wr) begin
        o_wr_count <= sat_inc(o_wr_count);
      end
      if (state == RD_WAIT) begin
        o_rd_count <= sat_inc(o_rd_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb/tb_sram_req_ctrl.sv - directed self-checking bench for sram_req_ctrl with a behavioural RAM
module tb_sram_req_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic       cs;
  logic       wr_e;
  logic       oe;
  logic [6:0] address;
  wire  [7:0] io_data;
`ifdef SRAM_REQ_CTRL_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] rd_count;
`endif

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;

  logic [7:0] model [0:127];
  logic [7:0] ram   [0:127];

  always #5 clk = ~clk;

  sram_req_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_wr    (req_wr),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rd_valid  (rd_valid),
    .o_rd_data   (rd_data),
    .o_busy      (busy),
    .o_cs        (cs),
    .o_wr_e      (wr_e),
    .o_oe        (oe),
    .o_address   (address),
`ifdef SRAM_REQ_CTRL_STATS_EN
    .o_wr_count  (wr_count),
    .o_rd_count  (rd_count),
`endif
    .io_data     (io_data)
  );

  // Behavioural single-port RAM: asynchronous read when selected with oe, write at clock edge
  assign io_data = (cs && oe && !wr_e) ? ram[address] : 8'bz;

  always @(posedge clk) begin
    if (cs && wr_e) ram[address] <= io_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Contention monitor: the controller must never drive while the RAM output is enabled
  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      assert (!(dut.drv_en && oe)) else begin
        bad++;
        $error("FAIL contention observed drv_en=%0b oe=%0b expected=no overlap", dut.drv_en, oe);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, input bit full);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    wait_ready("wr");
    tick();
    chk("wr_wr_e", {31'b0, wr_e}, 32'd1);
    chk("wr_io_data", {24'b0, io_data}, {24'b0, d});
    if (full) begin
      chk("wr_cs", {31'b0, cs}, 32'd1);
      chk("wr_oe", {31'b0, oe}, 32'd0);
      chk("wr_addr", {25'b0, address}, {25'b0, a});
      chk("wr_busy", {31'b0, busy}, 32'd1);
      chk("wr_not_ready", {31'b0, req_ready}, 32'd0);
    end
    // change the held request while not ready; it must have no effect
    req_wr   = 1'b0;
    req_addr = ~a;
    model[a] = d;
    tick();
    chk("wr_ready_again", {31'b0, req_ready}, 32'd1);
    chk("wr_cs_released", {31'b0, cs}, 32'd0);
    chk("wr_oe_idle", {31'b0, oe}, 32'd0);
    req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] a, input bit full);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = a;
    req_wdata = 8'($urandom);
    wait_ready("rd");
    tick();
    req_wr = 1'b1;
    if (full) begin
      chk("rda_cs", {31'b0, cs}, 32'd1);
      chk("rda_oe", {31'b0, oe}, 32'd1);
      chk("rda_wr_e", {31'b0, wr_e}, 32'd0);
      chk("rda_addr", {25'b0, address}, {25'b0, a});
      chk("rda_drv", {31'b0, dut.drv_en}, 32'd0);
      chk("rda_rd_valid", {31'b0, rd_valid}, 32'd0);
      chk("rda_not_ready", {31'b0, req_ready}, 32'd0);
    end
    tick();
    if (full) begin
      chk("rdw_cs", {31'b0, cs}, 32'd1);
      chk("rdw_oe", {31'b0, oe}, 32'd1);
      chk("rdw_drv", {31'b0, dut.drv_en}, 32'd0);
      chk("rdw_rd_valid", {31'b0, rd_valid}, 32'd0);
    end
    tick();
    req_valid = 1'b0;
    chk("turn_rd_valid", {31'b0, rd_valid}, 32'd1);
    chk("turn_rd_data", {24'b0, rd_data}, {24'b0, model[a]});
    if (full) begin
      chk("turn_cs", {31'b0, cs}, 32'd0);
      chk("turn_oe", {31'b0, oe}, 32'd0);
      chk("turn_drv", {31'b0, dut.drv_en}, 32'd0);
      chk("turn_not_ready", {31'b0, req_ready}, 32'd0);
    end
    tick();
    chk("rd_pulse_end", {31'b0, rd_valid}, 32'd0);
    chk("rd_ready_again", {31'b0, req_ready}, 32'd1);
    chk("rd_wr_e_idle", {31'b0, wr_e}, 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    mon_on = 1'b1;
    #11;
    chk("rst_cs", {31'b0, cs}, 32'd0);
    chk("rst_wr_e", {31'b0, wr_e}, 32'd0);
    chk("rst_oe", {31'b0, oe}, 32'd0);
    chk("rst_addr", {25'b0, address}, 32'd0);
    chk("rst_rd_data", {24'b0, rd_data}, 32'd0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready_held", {31'b0, req_ready}, 32'd0);
    chk("rst_drv", {31'b0, dut.drv_en}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_release_ready", {31'b0, req_ready}, 32'd1);

    // Fill the whole address space back-to-back, then read it all back
    for (int a = 0; a < 128; a++) do_write(7'(a), 8'(a) ^ 8'h5A, 1'b1);
    for (int a = 0; a < 128; a++) do_read(7'(a), 1'b1);

    // Top address, write then immediate read; rd_data must not move on the write
    do_write(7'h7F, 8'hA5, 1'b1);
    chk("rd_data_hold_on_write", {24'b0, rd_data}, {24'b0, 8'h7F ^ 8'h5A});
    do_read(7'h7F, 1'b1);
    chk("top_addr_data", {24'b0, rd_data}, 32'h0000_00A5);

`ifdef SRAM_REQ_CTRL_STATS_EN
    begin
      logic [15:0] wr0;
      logic [15:0] rd0;
      wr0 = wr_count;
      rd0 = rd_count;
      do_write(7'h01, 8'h11, 1'b0);
      do_write(7'h02, 8'h22, 1'b0);
      do_write(7'h03, 8'h33, 1'b0);
      do_read(7'h02, 1'b0);
      do_read(7'h03, 1'b0);
      chk("stats_wr_delta", {16'b0, wr_count - wr0}, 32'd3);
      chk("stats_rd_delta", {16'b0, rd_count - rd0}, 32'd2);
    end
`endif

    // Random mix with the contention monitor running throughout
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(1) == 1) do_write(7'($urandom), 8'($urandom), 1'b0);
      else do_read(7'($urandom), 1'b0);
    end

    // Reset in the middle of RD_WAIT
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 7'h05;
    wait_ready("mid_rst");
    tick();
    tick();
    chk("mid_rst_in_rd_wait", {31'b0, oe}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs", {31'b0, cs}, 32'd0);
    chk("mid_rst_oe", {31'b0, oe}, 32'd0);
    chk("mid_rst_drv", {31'b0, dut.drv_en}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    req_valid = 1'b0;
    tick();
    chk("mid_rst_no_valid", {31'b0, rd_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_valid", {31'b0, rd_valid}, 32'd0);
      chk("post_rst_cs", {31'b0, cs}, 32'd0);
    end

    // RAM contents survive a controller reset
    do_read(7'h7F, 1'b1);

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
